seq_coef_mult: RTL and testbench
================================

SEQ_COEF_MULT -- requirements
Module: seq_coef_mult

Interface
REQ-001 Parameter BIT_WIDTH, default 2, signed operand width.
REQ-002 Parameter COEF_WIDTH, default 8, signed coefficient width and the number of compute cycles.
REQ-003 Derived OUT_WIDTH = BIT_WIDTH+COEF_WIDTH (default 10), product width; SHALL NOT be overridable.
REQ-004 clk  input  1  single clock; all state changes on the rising edge.
REQ-005 rst_n  input  1  synchronous, active-low reset.
REQ-006 coef_load  input  1  request to load coef_in into the coefficient register.
REQ-007 coef_in  input  COEF_WIDTH  signed coefficient value.
REQ-008 in_valid  input  1  operand present on inp.
REQ-009 in_ready  output  1  block can accept an operand.
REQ-010 inp  input  BIT_WIDTH  signed operand.
REQ-011 out_valid  output  1  product available on out.
REQ-012 out_ready  input  1  consumer accepts the product.
REQ-013 out  output  OUT_WIDTH  signed product.
REQ-014 busy  output  1  high whenever state is not IDLE.

Function
REQ-015 The FSM SHALL have three states: IDLE, CALC and DONE.
REQ-016 in_ready SHALL be 1 in IDLE only; an accept is in_valid && in_ready sampled at a rising edge.
- Accept captures inp and the operand coefficient, clears the step counter and moves to CALC.
REQ-017 In IDLE with coef_load=1, the coefficient register SHALL load coef_in at the edge.
- coef_load SHALL be ignored in CALC and DONE.
REQ-018 Accept and coef_load in the same IDLE cycle: the operation SHALL use coef_in, and the register SHALL also load coef_in.
REQ-019 CALC SHALL last exactly COEF_WIDTH cycles, processing one coefficient bit per cycle (iterative shift-add, signed-correct).
- After the COEF_WIDTH-th CALC edge the state SHALL become DONE.
- out_valid SHALL go high COEF_WIDTH cycles after the accepting edge.
REQ-020 The product SHALL equal the exact two's-complement product inp*coef sign-extended to OUT_WIDTH, with no overflow, rounding or truncation.
REQ-021 In DONE, out_valid=1 and out SHALL stay stable until out_valid && out_ready at an edge.
- That handshake edge moves the state to IDLE.
REQ-022 After the handshake, out_valid=0 and out SHALL hold the last product until the next product completes.
- The intermediate accumulator SHALL never be visible on out.
REQ-023 in_valid in CALC or DONE SHALL be ignored with no side effects.
- Minimum initiation interval: COEF_WIDTH+2 cycles.
REQ-024 out_ready outside DONE SHALL have no effect.

Reset
REQ-025 With rst_n=0 at an edge, regardless of state, the block SHALL set:
- state IDLE, coefficient register 0, accumulator and counter 0;
- out=0, out_valid=0, busy=0, in_ready=1 on the following cycle.
REQ-026 Reset during CALC or DONE SHALL abort the operation with no product delivered.
- The first accept after reset SHALL behave as from power-up.

Verification
REQ-027 Reset then accept inp=1 with no coef load -> out_valid rises 8 cycles after accept, out=0.
REQ-028 Load coef=-128 (8'h80), accept inp=-2 -> out=256 (10'b0100000000) exactly 8 cycles after accept; coef=127, inp=-1 -> out=-127 (10'b1110000001).
REQ-029 Product -127 with out_ready held low 5 cycles -> out and out_valid stable, in_ready=0, in_valid pulses ignored; out_ready=1 -> IDLE next cycle, out still -127.
REQ-030 Load coef=3, accept inp=1, coef_load coef_in=5 at CALC cycle 4 -> out=3; next op inp=-1 -> out=-3.
REQ-031 IDLE cycle with coef_load=1, coef_in=10, in_valid=1, inp=-2 -> out=-20; following op inp=1 -> out=10.
REQ-032 rst_n=0 at CALC cycle 4 -> next cycle out_valid=0, out=0, busy=0, in_ready=1. Exhaustive sweep of all 4 inp x 256 coef values SHALL match a behavioural model with correct latency.

Source files
------------

// File: rtl/seq_coef_mult.sv
// Sequential signed multiplier. It processes one coefficient bit per cycle with shift-add.
// The result is held on out until the next product completes.
module seq_coef_mult #(
  parameter int  BIT_WIDTH  = 2,
  parameter int  COEF_WIDTH = 8,
  localparam int OUT_WIDTH  = BIT_WIDTH + COEF_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        coef_load,
  input  logic signed [COEF_WIDTH-1:0] coef_in,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [BIT_WIDTH-1:0] inp,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [OUT_WIDTH-1:0] out,
  output logic                        busy
);

  localparam int CNT_W = $clog2(COEF_WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e                       state_q, state_d;
  logic signed [COEF_WIDTH-1:0] coef_q, coef_d;
  // Operand coefficient. It shifts right each step, so bit 0 is always the current bit.
  logic signed [COEF_WIDTH-1:0] csh_q, csh_d;
  logic signed [OUT_WIDTH-1:0]  mcand_q, mcand_d;
  logic signed [OUT_WIDTH-1:0]  acc_q, acc_d;
  logic signed [OUT_WIDTH-1:0]  out_q, out_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;

  logic                         accept;
  logic                         last_step;
  logic signed [OUT_WIDTH-1:0]  acc_step;

  assign accept    = in_valid && (state_q == IDLE);
  assign last_step = (cnt_q == CNT_W'(COEF_WIDTH - 1));

  // The coefficient MSB carries weight -2^(N-1), so the last step subtracts.
  always_comb begin
    acc_step = acc_q;
    if (csh_q[0]) begin
      acc_step = last_step ? (acc_q - mcand_q) : (acc_q + mcand_q);
    end
  end

  // NOTE: every _d gets its hold value first, so paths that do not assign it cannot infer a latch.
  always_comb begin
    state_d = state_q;
    coef_d  = coef_q;
    csh_d   = csh_q;
    mcand_d = mcand_q;
    acc_d   = acc_q;
    out_d   = out_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (coef_load) coef_d = coef_in;
        if (accept) begin
          csh_d   = coef_load ? coef_in : coef_q;
          mcand_d = {{COEF_WIDTH{inp[BIT_WIDTH-1]}}, inp};
          acc_d   = '0;
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        acc_d   = acc_step;
        mcand_d = mcand_q <<< 1;
        csh_d   = csh_q >> 1;
        cnt_d   = cnt_q + CNT_W'(1);
        if (last_step) begin
          out_d   = acc_step;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments, so every flop samples the pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      coef_q  <= '0;
      csh_q   <= '0;
      mcand_q <= '0;
      acc_q   <= '0;
      out_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      coef_q  <= coef_d;
      csh_q   <= csh_d;
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
      out_q   <= out_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == DONE);
  assign out       = out_q;

endmodule

// File: tb/tb_seq_coef_mult.sv
// Self-checking bench for seq_coef_mult: a table of directed operations, multi-cycle corner
// sequences and a full operand x coefficient sweep against integer multiplication.
module tb_seq_coef_mult;

  localparam int BW = 2;
  localparam int CW = 8;
  localparam int OW = BW + CW;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 coef_load;
  logic signed [CW-1:0] coef_in;
  logic                 in_valid;
  logic                 in_ready;
  logic signed [BW-1:0] inp;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [OW-1:0] out;
  logic                 busy;

  int n_cmp = 0;
  int n_bad = 0;
  int last_prod = 0;

  typedef struct {
    logic signed [BW-1:0] a;
    bit                   load;
    logic signed [CW-1:0] c;
    int                   exp;
    string                name;
  } vec_t;

  vec_t vecs[7];

  always #5 clk = ~clk;

  seq_coef_mult #(.BIT_WIDTH(BW), .COEF_WIDTH(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .coef_load (coef_load),
    .coef_in   (coef_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .inp       (inp),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .busy      (busy)
  );

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic signed [BW-1:0] a, input bit load,
                          input logic signed [CW-1:0] c);
    inp       = a;
    in_valid  = 1'b1;
    coef_load = load;
    coef_in   = c;
    step();
    in_valid  = 1'b0;
    coef_load = 1'b0;
  endtask

  // k0 is the number of cycles already stepped since the accepting edge.
  task automatic wait_result(input string name, input int exp, input int k0);
    int k;
    bit leak;
    k    = k0;
    leak = 1'b0;
    while (!out_valid && k < CW + 4) begin
      if ($signed(out) != last_prod) leak = 1'b1;
      step();
      k++;
    end
    check({name, " latency"}, k, CW);
    check({name, " out"}, $signed(out), exp);
    check({name, " out held in CALC"}, {31'd0, leak}, 0);
    last_prod = exp;
  endtask

  task automatic handshake(input string name);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({name, " busy after hs"}, {31'd0, busy}, 0);
    check({name, " in_ready after hs"}, {31'd0, in_ready}, 1);
    check({name, " out_valid after hs"}, {31'd0, out_valid}, 0);
    check({name, " out held after hs"}, $signed(out), last_prod);
  endtask

  initial begin
    vecs[0] = '{a: 2'sd1,  load: 1'b0, c: 8'sd0,    exp: 0,    name: "no_load_after_reset"};
    vecs[1] = '{a: -2'sd2, load: 1'b1, c: -8'sd128, exp: 256,  name: "m2_x_m128"};
    vecs[2] = '{a: -2'sd1, load: 1'b1, c: 8'sd127,  exp: -127, name: "m1_x_127"};
    vecs[3] = '{a: 2'sd1,  load: 1'b0, c: 8'sd0,    exp: 127,  name: "reuse_reg_127"};
    vecs[4] = '{a: -2'sd2, load: 1'b1, c: -8'sd1,   exp: 2,    name: "m2_x_m1"};
    vecs[5] = '{a: 2'sd1,  load: 1'b1, c: -8'sd128, exp: -128, name: "1_x_m128"};
    vecs[6] = '{a: -2'sd2, load: 1'b0, c: 8'sd0,    exp: 256,  name: "reuse_reg_m128"};

    rst_n     = 1'b0;
    coef_load = 1'b0;
    coef_in   = '0;
    in_valid  = 1'b0;
    inp       = '0;
    out_ready = 1'b0;
    step();
    step();
    check("reset out", $signed(out), 0);
    check("reset out_valid", {31'd0, out_valid}, 0);
    check("reset busy", {31'd0, busy}, 0);
    check("reset in_ready", {31'd0, in_ready}, 1);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 7; i++) begin
      start_op(vecs[i].a, vecs[i].load, vecs[i].c);
      wait_result(vecs[i].name, vecs[i].exp, 0);
      handshake(vecs[i].name);
    end

    // Stall in DONE: output stable, new operands and coefficient loads ignored.
    start_op(-2'sd1, 1'b1, 8'sd127);
    wait_result("stall", -127, 0);
    begin
      bit unstable;
      unstable = 1'b0;
      for (int i = 0; i < 5; i++) begin
        in_valid  = i[0];
        inp       = 2'sd1;
        coef_load = 1'b1;
        coef_in   = 8'sd55;
        step();
        if (!out_valid || $signed(out) != -127 || in_ready || !busy) unstable = 1'b1;
      end
      check("stall outputs stable", {31'd0, unstable}, 0);
    end
    in_valid  = 1'b0;
    coef_load = 1'b0;
    handshake("stall");
    start_op(2'sd1, 1'b0, 8'sd0);
    wait_result("coef kept after stall", 127, 0);
    handshake("coef kept after stall");

    // coef_load during CALC cycle 4 affects neither the running product nor the register.
    start_op(2'sd1, 1'b1, 8'sd3);
    step();
    step();
    step();
    coef_load = 1'b1;
    coef_in   = 8'sd5;
    in_valid  = 1'b1;
    inp       = -2'sd2;
    step();
    coef_load = 1'b0;
    in_valid  = 1'b0;
    wait_result("load in calc", 3, 4);
    handshake("load in calc");
    start_op(-2'sd1, 1'b0, 8'sd0);
    wait_result("after load in calc", -3, 0);
    handshake("after load in calc");

    // Accept together with coef_load uses coef_in and also stores it.
    start_op(-2'sd2, 1'b1, 8'sd10);
    wait_result("accept with load", -20, 0);
    handshake("accept with load");
    start_op(2'sd1, 1'b0, 8'sd0);
    wait_result("reuse loaded 10", 10, 0);
    handshake("reuse loaded 10");

    // Reset in CALC cycle 4 aborts the operation.
    start_op(2'sd1, 1'b1, 8'sd7);
    step();
    step();
    step();
    rst_n = 1'b0;
    step();
    check("abort out_valid", {31'd0, out_valid}, 0);
    check("abort out", $signed(out), 0);
    check("abort busy", {31'd0, busy}, 0);
    check("abort in_ready", {31'd0, in_ready}, 1);
    rst_n     = 1'b1;
    last_prod = 0;
    begin
      bit spurious;
      spurious = 1'b0;
      for (int i = 0; i < 12; i++) begin
        step();
        if (out_valid || busy) spurious = 1'b1;
      end
      check("no product after abort", {31'd0, spurious}, 0);
    end
    start_op(-2'sd2, 1'b0, 8'sd0);
    wait_result("first op after abort", 0, 0);
    handshake("first op after abort");

    for (int a = -2; a <= 1; a++) begin
      for (int c = -128; c <= 127; c++) begin
        start_op(BW'(a), 1'b1, CW'(c));
        wait_result("sweep", a * c, 0);
        handshake("sweep");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
